// File: rtl/pc_unit.sv
// Fetch program counter with stall, redirect, exception entry/return and a
// one-deep buffer that keeps a redirect which lands during a stall.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_ADDR   = 32'h0000_4180,
  parameter int unsigned      STEP       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             pend,
  output logic             misalign
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state, state_next;
  logic [WIDTH-1:0] btgt, btgt_next;
  logic [WIDTH-1:0] pc_next, epc_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_ADDR;
      epc   <= '0;
      btgt  <= '0;
      state <= IDLE;
    end else begin
      pc    <= pc_next;
      epc   <= epc_next;
      btgt  <= btgt_next;
      state <= state_next;
    end
  end

  // Priority: exception, eret, stall (buffer redirect), live redirect,
  // buffered redirect, sequential.
  always_comb begin
    pc_next    = pc;
    epc_next   = epc;
    btgt_next  = btgt;
    state_next = state;
    if (exc_req) begin
      pc_next    = EXC_ADDR;
      epc_next   = exc_epc;
      state_next = IDLE;
    end else if (eret) begin
      pc_next    = epc;
      state_next = IDLE;
    end else if (stall) begin
      if (br_valid) begin
        btgt_next  = br_target;
        state_next = PEND;
      end
    end else if (br_valid) begin
      pc_next    = br_target;
      state_next = IDLE;
    end else if (state == PEND) begin
      pc_next    = btgt;
      state_next = IDLE;
    end else begin
      pc_next = pc + STEP_W;
    end
  end

  assign pc_plus  = pc + STEP_W;
  assign pend     = (state == PEND);
  assign misalign = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed walk through the main scenarios,
// then randomized traffic compared against a behavioural model every cycle.
module tb_pc_unit;

  localparam int          W          = 32;
  localparam logic [31:0] RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] EXC_ADDR   = 32'h0000_4180;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stall = 1'b0;
  logic         br_valid = 1'b0;
  logic [W-1:0] br_target = '0;
  logic         exc_req = 1'b0;
  logic [W-1:0] exc_epc = '0;
  logic         eret = 1'b0;
  logic [W-1:0] pc, pc_plus, epc;
  logic         pend, misalign;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] m_pc, m_epc, m_btgt;
  bit           m_has_buf;

  pc_unit #(.WIDTH(W), .RESET_ADDR(RESET_ADDR), .EXC_ADDR(EXC_ADDR), .STEP(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .exc_req(exc_req), .exc_epc(exc_epc), .eret(eret),
    .pc(pc), .pc_plus(pc_plus), .epc(epc), .pend(pend), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_pc = RESET_ADDR; m_epc = '0; m_btgt = '0; m_has_buf = 0;
    end else if (exc_req) begin
      m_pc = EXC_ADDR; m_epc = exc_epc; m_has_buf = 0;
    end else if (eret) begin
      m_pc = m_epc; m_has_buf = 0;
    end else if (stall) begin
      if (br_valid) begin
        m_btgt = br_target; m_has_buf = 1;
      end
    end else if (br_valid) begin
      m_pc = br_target; m_has_buf = 0;
    end else if (m_has_buf) begin
      m_pc = m_btgt; m_has_buf = 0;
    end else begin
      m_pc = W'((64'(m_pc) + 64'd4) % (64'd1 << W));
    end
  endtask

  task automatic check_model();
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, W'((64'(m_pc) + 64'd4) % (64'd1 << W)));
    chk("epc", epc, m_epc);
    chk("pend", W'(pend), W'(m_has_buf));
    chk("misalign", W'(misalign), W'((m_pc % 4) != 0));
  endtask

  // Apply one cycle of inputs, clock it, then compare against the model.
  task automatic cyc(input logic rst, input logic st, input logic bv,
                     input logic [W-1:0] bt, input logic ex,
                     input logic [W-1:0] ee, input logic er);
    reset = rst; stall = st; br_valid = bv; br_target = bt;
    exc_req = ex; exc_epc = ee; eret = er;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic branch(input logic [W-1:0] t);
    cyc(1'b1, 1'b0, 1'b1, t, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #1;
    // reset for two edges
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h1234, 1'b0, '0, 1'b0);
    chk("reset_pc", pc, 32'h3000);
    chk("reset_epc", epc, 32'h0);
    chk("reset_pend", W'(pend), 32'h0);
    idle(); chk("seq1", pc, 32'h3004);
    idle(); chk("seq2", pc, 32'h3008);
    idle(); chk("seq3", pc, 32'h300C);
    idle(); chk("seq4", pc, 32'h3010);

    branch(32'h3100); chk("br_pc", pc, 32'h3100);
    idle(); chk("br_next", pc, 32'h3104);
    chk("br_pend", W'(pend), 32'h0);

    // redirects during a stall, newest wins
    branch(32'h3020);
    cyc(1'b1, 1'b1, 1'b1, 32'h3200, 1'b0, '0, 1'b0);
    chk("stall1_pc", pc, 32'h3020); chk("stall1_pend", W'(pend), 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 32'h3300, 1'b0, '0, 1'b0);
    chk("stall2_pc", pc, 32'h3020);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("stall3_pc", pc, 32'h3020); chk("stall3_pend", W'(pend), 32'h1);
    idle(); chk("release_pc", pc, 32'h3300); chk("release_pend", W'(pend), 32'h0);
    idle(); chk("release_next", pc, 32'h3304);

    // exception entry under stall, then return
    branch(32'h3040);
    cyc(1'b1, 1'b1, 1'b1, 32'h3600, 1'b1, 32'h3040, 1'b0);
    chk("exc_pc", pc, 32'h4180); chk("exc_epc", epc, 32'h3040);
    chk("exc_pend", W'(pend), 32'h0);
    idle(); chk("handler", pc, 32'h4184);
    cyc(1'b1, 1'b1, 1'b1, 32'h3700, 1'b0, '0, 1'b1);
    chk("eret_pc", pc, 32'h3040);
    idle(); chk("eret_next", pc, 32'h3044);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h3048, 1'b1);
    chk("exc_eret_pc", pc, 32'h4180); chk("exc_eret_epc", epc, 32'h3048);

    // reset discards a buffered redirect
    cyc(1'b1, 1'b1, 1'b1, 32'h3500, 1'b0, '0, 1'b0);
    chk("buf_pend", W'(pend), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    chk("rst_buf_pc", pc, 32'h3000); chk("rst_buf_pend", W'(pend), 32'h0);
    chk("rst_buf_epc", epc, 32'h0);
    idle(); chk("no_3500", W'(pc !== 32'h3500), 32'h1); chk("after_rst", pc, 32'h3004);

    // wrap and misalignment
    branch(32'hFFFF_FFFC); chk("wrap_plus", pc_plus, 32'h0);
    idle(); chk("wrap_pc", pc, 32'h0);
    branch(32'h3002); chk("mis_flag", W'(misalign), 32'h1);
    chk("mis_pc", pc, 32'h3002);
    idle(); chk("mis_next", pc, 32'h3006);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] t;
      t = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(32'h3000 + ($urandom_range(0, 255) << 2));
      cyc($urandom_range(0, 63) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0,
          t,
          $urandom_range(0, 19) == 0,
          W'($urandom),
          $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
